// File: rtl/id_pipe.sv
// Instruction decode stage: a small circular queue of fetched {instr, pc} pairs
// feeding one registered decode output stage with valid/ready handshakes.
`timescale 1ns/1ps
module id_pipe #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [31:0]     if_instr_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            id_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [4:0]      id_rs1_idx_o,
  output logic [4:0]      id_rs2_idx_o,
  output logic [4:0]      id_rd_idx_o,
  output logic            id_rs1_en_o,
  output logic            id_rs2_en_o,
  output logic            id_rd_en_o,
  output logic [XLEN-1:0] id_imm_o,
  output logic [11:0]     id_opcode_info_o,
  output logic            id_ilegl_instr_o,
  output logic            id_ecall_o,
  output logic            id_ebreak_o,
  output logic            id_mret_o
);
  localparam int  PW   = $clog2(DEPTH);
  localparam int  CW   = PW + 1;
  localparam bit  RV64 = (XLEN == 64);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } q_ent_t;

  typedef struct packed {
    logic            rs1_en, rs2_en, rd_en;
    logic [XLEN-1:0] imm;
    logic [11:0]     info;
    logic            ill, ecall, ebreak, mret;
  } dec_t;

  q_ent_t          q_mem [DEPTH];
  q_ent_t          head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, load;
  dec_t            dec;

  // Ready looks only at registered count so ex_ready_i never reaches fetch.
  assign if_ready_o = rst_n_i & ~flush_i & (count < CW'(DEPTH));
  assign push       = if_valid_i & if_ready_o;
  assign load       = (count != '0) & (~id_valid_o | ex_ready_i);
  assign head       = q_mem[rd_ptr];

  always_ff @(posedge clk_i)
    if (push) q_mem[wr_ptr] <= '{instr: if_instr_i, pc: if_pc_i};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (load) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(load);
    end
  end

  // Decode of the queue head
  logic [31:0] ins;
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [11:0] cls;
  logic        legal, exc, ec, eb, mr;
  logic [31:0] imm32;

  assign ins = head.instr;
  assign op  = ins[6:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  always_comb begin
    cls   = '0;
    legal = 1'b0;
    ec    = 1'b0;
    eb    = 1'b0;
    mr    = 1'b0;
    if (ins[1:0] == 2'b11) begin
      case (op)
        7'b0010011: begin
          cls = 12'h800;
          case (f3)
            3'b001:  legal = RV64 ? (ins[31:26] == 6'b000000) : (f7 == 7'b0000000);
            3'b101:  legal = RV64 ? (ins[31:26] inside {6'b000000, 6'b010000})
                                  : (f7 inside {7'b0000000, 7'b0100000});
            default: legal = 1'b1;
          endcase
        end
        7'b0011011: begin
          cls   = 12'h400;
          legal = RV64 && ((f3 == 3'b000) || (f3 == 3'b001 && f7 == 7'b0000000) ||
                           (f3 == 3'b101 && f7 inside {7'b0000000, 7'b0100000}));
        end
        7'b0110011: begin
          cls   = 12'h200;
          legal = (f7 == 7'b0000000) || (f7 == 7'b0100000 && f3 inside {3'b000, 3'b101});
        end
        7'b0111011: begin
          cls   = 12'h100;
          legal = RV64 && ((f7 == 7'b0000000 && f3 inside {3'b000, 3'b001, 3'b101}) ||
                           (f7 == 7'b0100000 && f3 inside {3'b000, 3'b101}));
        end
        7'b1100011: begin cls = 12'h080; legal = !(f3 inside {3'b010, 3'b011}); end
        7'b1101111: begin cls = 12'h040; legal = 1'b1; end
        7'b1100111: begin cls = 12'h020; legal = (f3 == 3'b000); end
        7'b0000011: begin
          cls   = 12'h010;
          legal = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                  (RV64 && f3 inside {3'b011, 3'b110});
        end
        7'b0100011: begin
          cls   = 12'h008;
          legal = (f3 inside {3'b000, 3'b001, 3'b010}) || (RV64 && f3 == 3'b011);
        end
        7'b0110111: begin cls = 12'h004; legal = 1'b1; end
        7'b0010111: begin cls = 12'h002; legal = 1'b1; end
        7'b1110011: begin
          cls = 12'h001;
          if (f3 == 3'b000) begin
            ec    = (ins[19:7] == '0) && (ins[31:20] == 12'h000);
            eb    = (ins[19:7] == '0) && (ins[31:20] == 12'h001);
            mr    = (ins[19:7] == '0) && (ins[31:20] == 12'h302);
            legal = ec | eb | mr;
          end else begin
            legal = (f3 != 3'b100);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    imm32 = '0;
    if (cls[11] | cls[10] | cls[5] | cls[4]) imm32 = {{20{ins[31]}}, ins[31:20]};
    else if (cls[3]) imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    else if (cls[7]) imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    else if (cls[6]) imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    else if (cls[2] | cls[1]) imm32 = {ins[31:12], 12'b0};
  end

  assign exc = ec | eb | mr;

  always_comb begin
    dec        = '0;
    dec.ill    = ~legal;
    if (legal) begin
      dec.info   = cls;
      dec.imm    = XLEN'($signed(imm32));
      dec.ecall  = ec;
      dec.ebreak = eb;
      dec.mret   = mr;
      dec.rd_en  = (ins[11:7] != 5'd0) & ~cls[7] & ~cls[3] & ~exc;
      // csrr*i carry an immediate in the rs1 field, so no register read
      dec.rs1_en = ~cls[6] & ~cls[2] & ~cls[1] & ~(cls[0] & (exc | f3[2]));
      dec.rs2_en = cls[9] | cls[8] | cls[7] | cls[3];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      id_valid_o       <= 1'b0;
      id_pc_o          <= '0;
      id_rs1_idx_o     <= '0;
      id_rs2_idx_o     <= '0;
      id_rd_idx_o      <= '0;
      id_rs1_en_o      <= 1'b0;
      id_rs2_en_o      <= 1'b0;
      id_rd_en_o       <= 1'b0;
      id_imm_o         <= '0;
      id_opcode_info_o <= '0;
      id_ilegl_instr_o <= 1'b0;
      id_ecall_o       <= 1'b0;
      id_ebreak_o      <= 1'b0;
      id_mret_o        <= 1'b0;
    end else if (flush_i) begin
      id_valid_o <= 1'b0;
    end else if (load) begin
      id_valid_o       <= 1'b1;
      id_pc_o          <= head.pc;
      id_rs1_idx_o     <= ins[19:15];
      id_rs2_idx_o     <= ins[24:20];
      id_rd_idx_o      <= ins[11:7];
      id_rs1_en_o      <= dec.rs1_en;
      id_rs2_en_o      <= dec.rs2_en;
      id_rd_en_o       <= dec.rd_en;
      id_imm_o         <= dec.imm;
      id_opcode_info_o <= dec.info;
      id_ilegl_instr_o <= dec.ill;
      id_ecall_o       <= dec.ecall;
      id_ebreak_o      <= dec.ebreak;
      id_mret_o        <= dec.mret;
    end else if (ex_ready_i) begin
      id_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_id_pipe.sv
// Scoreboard bench for id_pipe: RV64 instance for flow control and decode,
// RV32 instance for width-dependent legality and sign extension.
`timescale 1ns/1ps
module tb_id_pipe;
  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  en;    // {rs1_en, rs2_en, rd_en}
    logic [63:0] imm;
    logic [11:0] info;
    logic [3:0]  flg;   // {ill, ecall, ebreak, mret}
  } exp_t;

  logic clk, rst_n, flush, if_valid, if_ready, id_valid, ex_ready;
  logic [31:0] instr;
  logic [63:0] pc, id_pc, id_imm;
  logic [4:0]  rs1, rs2, rd;
  logic        rs1_en, rs2_en, rd_en, ill, ecall, ebreak, mret;
  logic [11:0] info;

  logic        v32, rdy32, idv32, ex32, fl32;
  logic [31:0] ins32, pc32, idpc32, imm32;
  logic [4:0]  rs1_32, rs2_32, rd_32;
  logic        rs1e32, rs2e32, rde32, ill32, ec32, eb32, mr32;
  logic [11:0] info32;

  int errors = 0, checks = 0;
  exp_t sb[$], sb32[$];
  logic [63:0] next_pc = 64'h1000;
  logic [31:0] next_pc32 = 32'h400;

  id_pipe #(.XLEN(64), .DEPTH(2)) u64 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .if_valid_i(if_valid), .if_ready_o(if_ready),
    .if_instr_i(instr), .if_pc_i(pc), .id_valid_o(id_valid), .ex_ready_i(ex_ready), .id_pc_o(id_pc),
    .id_rs1_idx_o(rs1), .id_rs2_idx_o(rs2), .id_rd_idx_o(rd), .id_rs1_en_o(rs1_en),
    .id_rs2_en_o(rs2_en), .id_rd_en_o(rd_en), .id_imm_o(id_imm), .id_opcode_info_o(info),
    .id_ilegl_instr_o(ill), .id_ecall_o(ecall), .id_ebreak_o(ebreak), .id_mret_o(mret));

  id_pipe #(.XLEN(32), .DEPTH(2)) u32 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(fl32), .if_valid_i(v32), .if_ready_o(rdy32),
    .if_instr_i(ins32), .if_pc_i(pc32), .id_valid_o(idv32), .ex_ready_i(ex32), .id_pc_o(idpc32),
    .id_rs1_idx_o(rs1_32), .id_rs2_idx_o(rs2_32), .id_rd_idx_o(rd_32), .id_rs1_en_o(rs1e32),
    .id_rs2_en_o(rs2e32), .id_rd_en_o(rde32), .id_imm_o(imm32), .id_opcode_info_o(info32),
    .id_ilegl_instr_o(ill32), .id_ecall_o(ec32), .id_ebreak_o(eb32), .id_mret_o(mr32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [4:0] a, b, c, input logic [2:0] en,
                              input logic [63:0] imm, input logic [11:0] inf, input logic [3:0] flg);
    exp_t e;
    e = '{pc: 64'h0, rs1: a, rs2: b, rd: c, en: en, imm: imm, info: inf, flg: flg};
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ent(input string name, input exp_t a, input exp_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s pc=%h: got rs=%0d/%0d/%0d en=%b imm=%h info=%h flg=%b expected pc=%h rs=%0d/%0d/%0d en=%b imm=%h info=%h flg=%b",
               name, a.pc, a.rs1, a.rs2, a.rd, a.en, a.imm, a.info, a.flg,
               e.pc, e.rs1, e.rs2, e.rd, e.en, e.imm, e.info, e.flg);
    end
  endtask

  // Monitors: a transfer happens at the next rising edge when valid & ready.
  always @(negedge clk) begin : mon64
    exp_t act;
    #2;
    if (rst_n && id_valid && ex_ready && !flush) begin
      act = '{pc: id_pc, rs1: rs1, rs2: rs2, rd: rd, en: {rs1_en, rs2_en, rd_en}, imm: id_imm,
              info: info, flg: {ill, ecall, ebreak, mret}};
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL out64_unexpected: got pc %h expected no output", id_pc);
      end else chk_ent("out64", act, sb.pop_front());
    end
  end

  always @(negedge clk) begin : mon32
    exp_t act;
    #2;
    if (rst_n && idv32 && ex32) begin
      act = '{pc: {32'h0, idpc32}, rs1: rs1_32, rs2: rs2_32, rd: rd_32, en: {rs1e32, rs2e32, rde32},
              imm: {32'h0, imm32}, info: info32, flg: {ill32, ec32, eb32, mr32}};
      if (sb32.size() == 0) begin
        checks++; errors++;
        $display("FAIL out32_unexpected: got pc %h expected no output", idpc32);
      end else chk_ent("out32", act, sb32.pop_front());
    end
  end

  task automatic push(input logic [31:0] ins, input exp_t e, input bit rec);
    int t;
    t = 0;
    @(negedge clk);
    if_valid = 1'b1; instr = ins; pc = next_pc;
    #1;
    while (!if_ready && t < 20) begin @(negedge clk); #1; t++; end
    if (!if_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: got no ready for pc %h expected acceptance", next_pc);
    end else if (rec) begin
      e.pc = next_pc;
      sb.push_back(e);
    end
    next_pc += 64'd4;
    @(posedge clk);
  endtask

  task automatic push32(input logic [31:0] ins, input exp_t e);
    int t;
    t = 0;
    @(negedge clk);
    v32 = 1'b1; ins32 = ins; pc32 = next_pc32;
    #1;
    while (!rdy32 && t < 20) begin @(negedge clk); #1; t++; end
    if (!rdy32) begin
      checks++; errors++;
      $display("FAIL push32_timeout: got no ready for pc %h expected acceptance", next_pc32);
    end else begin
      e.pc = {32'h0, next_pc32};
      sb32.push_back(e);
    end
    next_pc32 += 32'd4;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); if_valid = 1'b0; v32 = 1'b0; end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; instr = '0; pc = '0; ex_ready = 1'b1;
    v32 = 1'b0; ins32 = '0; pc32 = '0; ex32 = 1'b1; fl32 = 1'b0;
    #12;
    chk("rst_valid", {63'h0, id_valid}, 64'h0);
    chk("rst_ready", {63'h0, if_ready}, 64'h0);
    chk("rst_imm", id_imm, 64'h0);
    chk("rst_info", {52'h0, info}, 64'h0);
    chk("rst_valid32", {63'h0, idv32}, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("post_rst_ready", {63'h0, if_ready}, 64'h1);

    // addi x1,x0,5: one edge to queue, one edge to stage
    push(32'h00500093, mk(0, 5, 1, 3'b101, 64'd5, 12'h800, 4'b0000), 1);
    @(negedge clk); if_valid = 1'b0;
    #2 chk("latency_edge1", {63'h0, id_valid}, 64'h0);
    @(negedge clk);
    #2 chk("latency_edge2", {63'h0, id_valid}, 64'h1);

    // back-to-back decode vectors
    push(32'h80000137, mk(0, 0, 2, 3'b001, 64'hFFFFFFFF80000000, 12'h004, 4'b0000), 1);
    push(32'h00208463, mk(1, 2, 8, 3'b110, 64'd8, 12'h080, 4'b0000), 1);
    push(32'h0020A463, mk(1, 2, 8, 3'b000, 64'd0, 12'h000, 4'b1000), 1);
    push(32'hFE512E23, mk(2, 5, 28, 3'b110, 64'hFFFFFFFFFFFFFFFC, 12'h008, 4'b0000), 1);
    push(32'h001000EF, mk(0, 1, 1, 3'b001, 64'h800, 12'h040, 4'b0000), 1);
    push(32'h02009093, mk(1, 0, 1, 3'b101, 64'd32, 12'h800, 4'b0000), 1);
    push(32'h02000033, mk(0, 0, 0, 3'b000, 64'd0, 12'h000, 4'b1000), 1);
    push(32'h3002D1F3, mk(5, 0, 3, 3'b001, 64'd0, 12'h001, 4'b0000), 1);
    push(32'h00013083, mk(2, 0, 1, 3'b101, 64'd0, 12'h010, 4'b0000), 1);
    push(32'h0010009B, mk(0, 1, 1, 3'b101, 64'd1, 12'h400, 4'b0000), 1);
    push(32'h00000073, mk(0, 0, 0, 3'b000, 64'd0, 12'h001, 4'b0100), 1);
    push(32'h00100073, mk(0, 1, 0, 3'b000, 64'd0, 12'h001, 4'b0010), 1);
    push(32'h30200073, mk(0, 2, 0, 3'b000, 64'd0, 12'h001, 4'b0001), 1);
    push(32'h00500090, mk(0, 5, 1, 3'b000, 64'd0, 12'h000, 4'b1000), 1);
    idle(4);

    // backpressure: 2 queued + 1 staged, fourth refused, then drain one per cycle
    @(negedge clk); ex_ready = 1'b0;
    push(32'h00100113, mk(0, 1, 2, 3'b101, 64'd1, 12'h800, 4'b0000), 1);
    push(32'h00200193, mk(0, 2, 3, 3'b101, 64'd2, 12'h800, 4'b0000), 1);
    push(32'h00300213, mk(0, 3, 4, 3'b101, 64'd3, 12'h800, 4'b0000), 1);
    @(negedge clk); if_valid = 1'b1; instr = 32'h00400293; pc = 64'hDEAD;
    #1 chk("full_ready", {63'h0, if_ready}, 64'h0);
    @(negedge clk); if_valid = 1'b0; ex_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2 chk($sformatf("drain_%0d", k), {63'h0, id_valid}, 64'h1);
      @(negedge clk);
    end
    #2 chk("drained", {63'h0, id_valid}, 64'h0);

    // flush with queue full and stage occupied, plus a concurrent offer
    @(negedge clk); ex_ready = 1'b0;
    push(32'h00700393, '0, 0);
    push(32'h00800413, '0, 0);
    push(32'h00900493, '0, 0);
    @(negedge clk); flush = 1'b1; if_valid = 1'b1; instr = 32'h00A00513; pc = 64'hBEEF;
    #1 chk("flush_ready", {63'h0, if_ready}, 64'h0);
    @(negedge clk); flush = 1'b0; if_valid = 1'b0;
    #1 chk("flush_valid", {63'h0, id_valid}, 64'h0);
    chk("flush_empty", {63'h0, if_ready}, 64'h1);
    ex_ready = 1'b1;
    idle(4);
    push(32'h00B00593, mk(0, 11, 11, 3'b101, 64'd11, 12'h800, 4'b0000), 1);
    idle(4);

    // asynchronous reset mid-stream
    @(negedge clk); ex_ready = 1'b0;
    push(32'h00C00613, '0, 0);
    push(32'h00D00693, '0, 0);
    @(negedge clk); if_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk("async_rst_valid", {63'h0, id_valid}, 64'h0);
    chk("async_rst_ready", {63'h0, if_ready}, 64'h0);
    chk("async_rst_imm", id_imm, 64'h0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1; ex_ready = 1'b1;
    push(32'h00E00713, mk(0, 14, 14, 3'b101, 64'd14, 12'h800, 4'b0000), 1);
    idle(4);

    // RV32 legality and sign extension
    push32(32'h0010009B, mk(0, 1, 1, 3'b000, 64'd0, 12'h000, 4'b1000));
    push32(32'h02009093, mk(1, 0, 1, 3'b000, 64'd0, 12'h000, 4'b1000));
    push32(32'h00013083, mk(2, 0, 1, 3'b000, 64'd0, 12'h000, 4'b1000));
    push32(32'h80000137, mk(0, 0, 2, 3'b001, 64'h80000000, 12'h004, 4'b0000));
    push32(32'h00500093, mk(0, 5, 1, 3'b101, 64'd5, 12'h800, 4'b0000));
    idle(2);

    begin
      int t;
      t = 0;
      while ((sb.size() != 0 || sb32.size() != 0) && t < 100) begin @(negedge clk); t++; end
      checks++;
      if (sb.size() != 0 || sb32.size() != 0) begin
        errors++;
        $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", sb.size(), sb32.size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
